// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues in-order memory reads for the PC generator,
// tracks outstanding fetches in a circular return queue, and hands instructions
// back in request order. Fetches are discarded on flush, and responses that
// belong to flushed requests are counted off and dropped.
module ifetch_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            next_pc_valide,
    input  logic [XLEN-1:0] next_pc,
    input  logic            flush,
    output logic            mem_req_v,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_rdy,
    input  logic            mem_rsp_v,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] instruction,
    output logic            instruction_v,
    input  logic            ok,
    output logic            fault,
    output logic            protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [DEPTH-1:0] fault_q, fault_d;
    logic            perr_q, perr_d;
    logic [XLEN-1:0] data_q [DEPTH];

    logic [CW:0]     occupancy;
    logic            credit;
    logic            aligned;
    logic            req_ok;
    logic            fault_alloc;
    logic            alloc;
    logic            pop;
    logic            fill_hit;
    logic [PW-1:0]   fill_idx;
    logic [CW-1:0]   unfilled_cnt;
    logic            rsp_fill;
    logic            rsp_drop;
    logic            rsp_spur;

    // Flushed requests still returning data hold credit until they come back,
    // so the memory never sees more than DEPTH outstanding reads.
    assign occupancy    = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign credit       = occupancy < (CW + 1)'(DEPTH);
    assign aligned      = (next_pc[1:0] == 2'b00);
    assign req_ok       = next_pc_valide & credit & ~flush & ~rst;
    assign mem_req_v    = req_ok & aligned;
    assign mem_req_addr = next_pc;
    assign fault_alloc  = req_ok & ~aligned;
    assign alloc        = (mem_req_v & mem_req_rdy) | fault_alloc;

    assign instruction_v = ~rst & filled_q[rd_ptr_q] & (alloc_cnt_q != '0);
    assign instruction   = instruction_v ? data_q[rd_ptr_q] : '0;
    assign fault         = instruction_v & fault_q[rd_ptr_q];
    assign protocol_err  = perr_q;
    assign pop           = instruction_v & ok & ~flush;

    // Locate the oldest allocated slot still awaiting memory data (fault slots
    // are born filled and are skipped) and count all such slots for flush.
    always_comb begin
        fill_hit     = 1'b0;
        fill_idx     = '0;
        unfilled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            logic [PW-1:0] off;
            idx = fill_ptr_q + PW'(i);
            off = idx - rd_ptr_q;
            if (({1'b0, off} < alloc_cnt_q) && !filled_q[idx] && !fill_hit) begin
                fill_hit = 1'b1;
                fill_idx = idx;
            end
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < alloc_cnt_q) && !filled_q[i])
                unfilled_cnt = unfilled_cnt + CW'(1);
        end
    end

    assign rsp_drop = mem_rsp_v & (drop_cnt_q != '0);
    assign rsp_fill = mem_rsp_v & (drop_cnt_q == '0) & fill_hit;
    assign rsp_spur = mem_rsp_v & (drop_cnt_q == '0) & ~fill_hit;

    // Next-state for queue control: flush wipes the queue and converts every
    // outstanding memory slot into a pending drop.
    always_comb begin
        logic [CW-1:0] drop_sum;
        wr_ptr_d    = wr_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        filled_d    = filled_q;
        fault_d     = fault_q;
        perr_d      = perr_q | rsp_spur;
        drop_sum    = drop_cnt_q + unfilled_cnt;
        if (flush) begin
            wr_ptr_d    = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            alloc_cnt_d = '0;
            filled_d    = '0;
            fault_d     = '0;
            if (mem_rsp_v && (drop_sum != '0))
                drop_sum = drop_sum - CW'(1);
            drop_cnt_d  = drop_sum;
        end else begin
            if (alloc) begin
                filled_d[wr_ptr_q] = fault_alloc;
                fault_d[wr_ptr_q]  = fault_alloc;
                wr_ptr_d           = wr_ptr_q + PW'(1);
            end
            if (rsp_fill) begin
                filled_d[fill_idx] = 1'b1;
                fault_d[fill_idx]  = 1'b0;
                fill_ptr_d         = fill_idx + PW'(1);
            end
            if (rsp_drop)
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(alloc) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
            fault_q     <= '0;
            perr_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
            fault_q     <= fault_d;
            perr_q      <= perr_d;
        end
    end

    // Slot data storage; validity is carried by filled_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (rsp_fill && !flush && !rst)
            data_q[fill_idx] <= mem_rsp_data;
        if (fault_alloc)
            data_q[wr_ptr_q] <= '0;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scenario bench for ifetch_unit: expected memory addresses and returned
// instructions are queued as stimulus is driven and compared by a monitor.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_pc_valide;
    logic [31:0] next_pc;
    logic        flush;
    logic        mem_req_v;
    logic [31:0] mem_req_addr;
    logic        mem_req_rdy;
    logic        mem_rsp_v;
    logic [31:0] mem_rsp_data;
    logic [31:0] instruction;
    logic        instruction_v;
    logic        ok;
    logic        fault;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr [$];
    logic [32:0] exp_out  [$];
    logic [31:0] rsp_pend [$];

    ifetch_unit #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .next_pc_valide(next_pc_valide), .next_pc(next_pc), .flush(flush),
        .mem_req_v(mem_req_v), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
        .mem_rsp_v(mem_rsp_v), .mem_rsp_data(mem_rsp_data),
        .instruction(instruction), .instruction_v(instruction_v), .ok(ok),
        .fault(fault), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_v && mem_req_rdy) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL mem_req: unexpected request addr=%h", mem_req_addr);
                end else begin
                    logic [31:0] a;
                    a = exp_addr.pop_front();
                    if (mem_req_addr !== a) begin
                        errors++;
                        $display("FAIL mem_req_addr: got %h expected %h", mem_req_addr, a);
                    end
                end
            end
            if (instruction_v && ok && !flush) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL instr: unexpected output instr=%h fault=%b", instruction, fault);
                end else begin
                    logic [32:0] e;
                    e = exp_out.pop_front();
                    if ({fault, instruction} !== e) begin
                        errors++;
                        $display("FAIL instr: got fault=%b instr=%h expected fault=%b instr=%h",
                                 fault, instruction, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle fetch request; aligned ones expect a memory read and later data.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input bit expect_out);
        next_pc_valide = 1'b1;
        next_pc        = addr;
        if (addr[1:0] == 2'b00) begin
            exp_addr.push_back(addr);
            rsp_pend.push_back(data);
            if (expect_out) exp_out.push_back({1'b0, data});
        end else if (expect_out) begin
            exp_out.push_back({1'b1, 32'h0});
        end
        tick();
        next_pc_valide = 1'b0;
    endtask

    task automatic respond();
        mem_rsp_v    = 1'b1;
        mem_rsp_data = rsp_pend.pop_front();
        tick();
        mem_rsp_v    = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (exp_out.size() != 0 || exp_addr.size() != 0); i++)
            tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; next_pc_valide = 1'b1; next_pc = 32'h0; flush = 1'b0;
        mem_req_rdy = 1'b1; mem_rsp_v = 1'b0; mem_rsp_data = 32'h0; ok = 1'b1;
        tick(); tick();
        checks++; if (mem_req_v !== 1'b0) begin errors++; $display("FAIL reset_mem_req_v: got %b expected 0", mem_req_v); end
        checks++; if (instruction_v !== 1'b0) begin errors++; $display("FAIL reset_instr_v: got %b expected 0", instruction_v); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
        next_pc_valide = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        ok = 1'b1;
        send(32'h0, 32'h13, 1);
        send(32'h4, 32'h93, 1);
        send(32'h8, 32'h113, 1);
        repeat (3) respond();
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL stream_drain: %0d outputs missing expected 0", exp_out.size()); end
    endtask

    task automatic test_misaligned();
        ok = 1'b1;
        send(32'h0, 32'h13, 1);
        next_pc_valide = 1'b1; next_pc = 32'h6; exp_out.push_back({1'b1, 32'h0});
        #1;
        checks++; if (mem_req_v !== 1'b0) begin errors++; $display("FAIL misaligned_req: mem_req_v got %b expected 0", mem_req_v); end
        tick();
        next_pc_valide = 1'b0;
        send(32'h8, 32'h2a2a, 1);
        repeat (2) respond();
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL misaligned_drain: %0d outputs missing expected 0", exp_out.size()); end
    endtask

    task automatic test_full();
        ok = 1'b1;
        send(32'h10, 32'hA0, 1);
        send(32'h14, 32'hA4, 1);
        send(32'h18, 32'hA8, 1);
        send(32'h1C, 32'hAC, 1);
        next_pc_valide = 1'b1; next_pc = 32'h20;
        #1;
        checks++; if (mem_req_v !== 1'b0) begin errors++; $display("FAIL full_credit: mem_req_v got %b expected 0", mem_req_v); end
        tick();
        checks++; if (mem_req_v !== 1'b0) begin errors++; $display("FAIL full_credit_hold: mem_req_v got %b expected 0", mem_req_v); end
        next_pc_valide = 1'b0;
        respond();
        tick(); tick();
        next_pc_valide = 1'b1; next_pc = 32'h20;
        #1;
        checks++; if (mem_req_v !== 1'b1) begin errors++; $display("FAIL full_restore: mem_req_v got %b expected 1", mem_req_v); end
        exp_addr.push_back(32'h20); rsp_pend.push_back(32'hB0); exp_out.push_back({1'b0, 32'hB0});
        tick();
        next_pc_valide = 1'b0;
        repeat (4) respond();
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL full_drain: %0d outputs missing expected 0", exp_out.size()); end
    endtask

    task automatic test_flush();
        ok = 1'b1;
        send(32'h40, 32'hDEAD0001, 0);
        send(32'h44, 32'hDEAD0002, 0);
        send(32'h48, 32'hDEAD0003, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (instruction_v !== 1'b0) begin errors++; $display("FAIL flush_instr_v: got %b expected 0", instruction_v); end
        send(32'h100, 32'hABC, 1);
        next_pc_valide = 1'b1; next_pc = 32'h104;
        #1;
        checks++; if (mem_req_v !== 1'b0) begin errors++; $display("FAIL flush_credit: mem_req_v got %b expected 0", mem_req_v); end
        next_pc_valide = 1'b0;
        for (int i = 0; i < 3; i++) begin
            respond();
            checks++; if (instruction_v !== 1'b0) begin errors++; $display("FAIL flush_drop%0d: instruction_v got %b expected 0", i, instruction_v); end
        end
        respond();
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL flush_drain: %0d outputs missing expected 0", exp_out.size()); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL flush_perr: got %b expected 0", protocol_err); end
    endtask

    task automatic test_back_to_back();
        ok = 1'b1;
        send(32'h300, 32'h1111, 1);
        next_pc_valide = 1'b1; next_pc = 32'h304;
        exp_addr.push_back(32'h304); exp_out.push_back({1'b0, 32'h2222});
        mem_rsp_v = 1'b1; mem_rsp_data = rsp_pend.pop_front();
        rsp_pend.push_back(32'h2222);
        tick();
        next_pc = 32'h308;
        exp_addr.push_back(32'h308); exp_out.push_back({1'b0, 32'h3333});
        mem_rsp_data = rsp_pend.pop_front();
        rsp_pend.push_back(32'h3333);
        tick();
        next_pc_valide = 1'b0; mem_rsp_v = 1'b0;
        respond();
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d outputs missing expected 0", exp_out.size()); end
    endtask

    task automatic test_backpressure();
        ok = 1'b0;
        send(32'h200, 32'h111, 1);
        send(32'h204, 32'h222, 1);
        repeat (2) respond();
        for (int i = 0; i < 5; i++) begin
            checks++; if (instruction_v !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected 1", i, instruction_v); end
            checks++; if (instruction !== 32'h111) begin errors++; $display("FAIL bp_hold%0d: got %h expected 00000111", i, instruction); end
            tick();
        end
        ok = 1'b1;
        drain(20);
        checks++; if (exp_out.size() != 0) begin errors++; $display("FAIL bp_drain: %0d outputs missing expected 0", exp_out.size()); end
    endtask

    task automatic test_spurious();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL spur_pre: got %b expected 0", protocol_err); end
        mem_rsp_v = 1'b1; mem_rsp_data = 32'hBAD;
        tick();
        mem_rsp_v = 1'b0;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL spur_set: got %b expected 1", protocol_err); end
        tick(); tick(); tick();
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b expected 1", protocol_err); end
        checks++; if (instruction_v !== 1'b0) begin errors++; $display("FAIL spur_instr_v: got %b expected 0", instruction_v); end
        rst = 1'b1; tick();
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b expected 0", protocol_err); end
        rst = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_misaligned();
        test_full();
        test_flush();
        test_back_to_back();
        test_backpressure();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
